regfile_wb_sched: RTL and testbench
===================================

// Module: regfile_wb_sched
// PURPOSE
//  Writeback scheduler driving both write ports (A, B) of the dual-issue register file.
//  Merges two in-order pipeline lanes with out-of-band multiply/divide results.
//  MD results are queued in a small FIFO and issued on whichever write port a lane leaves idle.
//  Resolves write-after-write (WAW) ordering so that an older queued result never overwrites a younger lane write.
// PARAMETERS
//  DEPTH   4   MD result queue entries (power of 2, >=2)
// PORTS
//  clock               in   1   system clock
//  ctrl_reset          in   1   synchronous, active-high reset
//  lane_a_valid        in   1   lane A result valid (always accepted)
//  lane_a_rd           in   5   lane A destination register
//  lane_a_data         in   32  lane A result
//  lane_b_valid        in   1   lane B result valid (always accepted; younger than lane A)
//  lane_b_rd           in   5   lane B destination register
//  lane_b_data         in   32  lane B result
//  md_valid            in   1   MD result offered
//  md_ready            out  1   queue can accept (= !full)
//  md_rd               in   5   MD destination register
//  md_data             in   32  MD result
//  A_ctrl_writeEnable  out  1   to regfile write port A
//  A_ctrl_writeReg     out  5
//  A_data_writeReg     out  32
//  B_ctrl_writeEnable  out  1   to regfile write port B
//  B_ctrl_writeReg     out  5
//  B_data_writeReg     out  32
// BEHAVIOUR
//  - Reset: queue empty, all live bits 0; every write-port output is 0; md_ready=1 in the first cycle after reset.
//  - All write-port outputs are registered: a decision made in cycle N appears on the ports in cycle N+1.
//  - Lane writes: lane_x_valid && lane_x_rd!=0 -> port X writes (rd, data) next cycle.
//  - Lane conflict: A and B valid with equal nonzero rd -> drop A; only B writes.
//  - MD accept: md_valid && md_ready -> enqueue {live=1, rd, data}.
//  - MD accept with md_rd==0 -> handshake completes, nothing is enqueued.
//  - md_ready is purely !full; there is no enqueue/dequeue pass-through when full.
//  - Squash: each cycle, any queued or incoming MD entry whose rd equals a valid nonzero lane rd gets live cleared.
//    Rationale: MD results are older than the current lane writes.
//  - Head issue, evaluated each cycle against the current lane inputs:
//     * head dead -> pop; no port is used.
//     * head live, port A free -> issue on A, pop.
//     * else head live, port B free -> issue on B, pop.
//     * else hold the head (stall).
//    A port is free when its lane is not writing (valid=0, rd=0, or dropped by the lane-conflict rule).
//  - At most one pop per cycle; only the head is issued.
//  - Queue pointers wrap modulo DEPTH; a separate count distinguishes full from empty.
//  - Simultaneous enqueue + pop is allowed whenever not full; count is unchanged.
//  - ctrl_reset mid-operation: queued entries are discarded, not written; ports are 0 the next cycle.
// CONFIGURATION
//  WB_PENDING_EN defined:
//   - adds output pending_mask [31:0], registered.
//   - bit r = 1 iff a live queued entry targets r, as of after this cycle's squash/enqueue/pop.
//   - reset value 0.
//   - decode stage uses it to stall RAW hazards on in-flight MD results.
//  WB_PENDING_EN undefined: port and logic are absent; all other behaviour is identical.
// TESTING
//  1. Lane A (rd=3, 0x11) and lane B (rd=4, 0x22) in one cycle -> next cycle A writes r3=0x11, B writes r4=0x22.
//  2. Lanes A and B both target rd=5 (0xAA / 0xBB) -> only B writes r5=0xBB; A_ctrl_writeEnable=0.
//  3. MD rd=7, 0x77 while lane A is idle -> one cycle later A writes r7=0x77; queue empty.
//  4. Fill 4 MD entries while both lanes are busy -> md_ready=0.
//     Then free lane B -> one pop per cycle via port B, in order; md_ready=1 after the first pop.
//  5. Queue r9=0x99, then lane A writes r9=0x01 -> queued entry squashed; r9 ends 0x01.
//     With WB_PENDING_EN: pending_mask[9] clears.
//  6. Reset with 3 live entries -> no further writes; md_ready=1, outputs 0.
//     With WB_PENDING_EN: pending_mask=0.

Source files
------------

// File: rtl/regfile_wb_sched_if.sv
// Writeback scheduler bus: the two lane results, the MD result handshake and
// both register-file write ports. The scheduler takes the slave side.
interface regfile_wb_sched_if;
  logic        lane_a_valid;
  logic [4:0]  lane_a_rd;
  logic [31:0] lane_a_data;
  logic        lane_b_valid;
  logic [4:0]  lane_b_rd;
  logic [31:0] lane_b_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        A_ctrl_writeEnable;
  logic [4:0]  A_ctrl_writeReg;
  logic [31:0] A_data_writeReg;
  logic        B_ctrl_writeEnable;
  logic [4:0]  B_ctrl_writeReg;
  logic [31:0] B_data_writeReg;

  modport master (
    output lane_a_valid, lane_a_rd, lane_a_data,
    output lane_b_valid, lane_b_rd, lane_b_data,
    output md_valid, md_rd, md_data,
    input  md_ready,
    input  A_ctrl_writeEnable, A_ctrl_writeReg, A_data_writeReg,
    input  B_ctrl_writeEnable, B_ctrl_writeReg, B_data_writeReg
  );

  modport slave (
    input  lane_a_valid, lane_a_rd, lane_a_data,
    input  lane_b_valid, lane_b_rd, lane_b_data,
    input  md_valid, md_rd, md_data,
    output md_ready,
    output A_ctrl_writeEnable, A_ctrl_writeReg, A_data_writeReg,
    output B_ctrl_writeEnable, B_ctrl_writeReg, B_data_writeReg
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler for the dual-issue register file.
// Lane A/B results own write ports A/B; queued multiply/divide results fill
// whichever port is idle. Queued entries whose destination is written by a
// lane in the same cycle are killed, since the lane result is younger.
// Optional feature: define WB_PENDING_EN to add the registered pending_mask
// output (one bit per register with a live queued result).
module regfile_wb_sched #(
  parameter int DEPTH = 4
) (
  input  logic               clock,
  input  logic               ctrl_reset,
  regfile_wb_sched_if.slave  wb
`ifdef WB_PENDING_EN
  ,
  output logic [31:0]        pending_mask
`endif
);

  localparam int AW = $clog2(DEPTH);

  // Queue storage; live bits are only ever set in occupied slots.
  logic [DEPTH-1:0] live_q, live_d, live_sq;
  logic [4:0]       rd_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [AW:0]      count_q, count_d;

  // Registered write-port outputs.
  logic        a_en_q, a_en_d, b_en_q, b_en_d;
  logic [4:0]  a_reg_q, a_reg_d, b_reg_q, b_reg_d;
  logic [31:0] a_dat_q, a_dat_d, b_dat_q, b_dat_d;

  logic a_busy, b_busy, a_wr, b_wr;
  logic not_empty, head_live, pop, issue_a, issue_b, enq, md_hit;

  function automatic logic lane_hit(input logic [4:0] rd, input logic av,
                                    input logic [4:0] ard, input logic bv,
                                    input logic [4:0] brd);
    return (av && rd == ard) || (bv && rd == brd);
  endfunction

  // A lane "claims" its register when valid with a nonzero rd; A yields to B
  // on a shared destination because B is the younger instruction.
  assign a_busy = wb.lane_a_valid && (wb.lane_a_rd != '0);
  assign b_busy = wb.lane_b_valid && (wb.lane_b_rd != '0);
  assign a_wr   = a_busy && !(b_busy && (wb.lane_b_rd == wb.lane_a_rd));
  assign b_wr   = b_busy;

  // Kill any queued result that a lane overwrites this cycle.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_squash
      assign live_sq[gi] = live_q[gi] &&
        !lane_hit(rd_q[gi], a_busy, wb.lane_a_rd, b_busy, wb.lane_b_rd);
    end
  endgenerate

  assign not_empty   = (count_q != '0);
  assign head_live   = live_sq[head_q];
  assign issue_a     = not_empty && head_live && !a_wr;
  assign issue_b     = not_empty && head_live && a_wr && !b_wr;
  // Dead heads are dropped without using a port.
  assign pop         = not_empty && (!head_live || issue_a || issue_b);
  assign wb.md_ready = (count_q != (AW+1)'(DEPTH));
  // rd==0 results complete the handshake but are never stored.
  assign enq         = wb.md_valid && wb.md_ready && (wb.md_rd != '0);
  assign md_hit      = lane_hit(wb.md_rd, a_busy, wb.lane_a_rd, b_busy, wb.lane_b_rd);

  // Next queue state: squash, then retire the head, then append the new entry.
  always_comb begin
    live_d = live_sq;
    if (pop) live_d[head_q] = 1'b0;
    if (enq) live_d[tail_q] = !md_hit;
    head_d  = head_q + AW'(pop);
    tail_d  = tail_q + AW'(enq);
    count_d = count_q + (AW+1)'(enq) - (AW+1)'(pop);
  end

  // Next write-port values; an idle port presents all zeros.
  always_comb begin
    a_en_d  = 1'b0;
    a_reg_d = '0;
    a_dat_d = '0;
    b_en_d  = 1'b0;
    b_reg_d = '0;
    b_dat_d = '0;
    if (a_wr) begin
      a_en_d  = 1'b1;
      a_reg_d = wb.lane_a_rd;
      a_dat_d = wb.lane_a_data;
    end else if (issue_a) begin
      a_en_d  = 1'b1;
      a_reg_d = rd_q[head_q];
      a_dat_d = data_q[head_q];
    end
    if (b_wr) begin
      b_en_d  = 1'b1;
      b_reg_d = wb.lane_b_rd;
      b_dat_d = wb.lane_b_data;
    end else if (issue_b) begin
      b_en_d  = 1'b1;
      b_reg_d = rd_q[head_q];
      b_dat_d = data_q[head_q];
    end
  end

  // Control state and output registers; reset discards all queued entries.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      live_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      a_en_q  <= 1'b0;
      a_reg_q <= '0;
      a_dat_q <= '0;
      b_en_q  <= 1'b0;
      b_reg_q <= '0;
      b_dat_q <= '0;
    end else begin
      live_q  <= live_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      a_en_q  <= a_en_d;
      a_reg_q <= a_reg_d;
      a_dat_q <= a_dat_d;
      b_en_q  <= b_en_d;
      b_reg_q <= b_reg_d;
      b_dat_q <= b_dat_d;
    end
  end

  // Payload storage needs no reset: the live bits qualify every slot.
  always_ff @(posedge clock) begin
    if (enq) begin
      rd_q[tail_q]   <= wb.md_rd;
      data_q[tail_q] <= wb.md_data;
    end
  end

  assign wb.A_ctrl_writeEnable = a_en_q;
  assign wb.A_ctrl_writeReg    = a_reg_q;
  assign wb.A_data_writeReg    = a_dat_q;
  assign wb.B_ctrl_writeEnable = b_en_q;
  assign wb.B_ctrl_writeReg    = b_reg_q;
  assign wb.B_data_writeReg    = b_dat_q;

`ifdef WB_PENDING_EN
  logic [31:0] pend_q, pend_d;

  // Registers targeted by live entries after this cycle's queue update.
  always_comb begin
    pend_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_d[i]) begin
        if (enq && (tail_q == AW'(i))) pend_d[wb.md_rd] = 1'b1;
        else                           pend_d[rd_q[i]] = 1'b1;
      end
    end
  end

  // Pending mask register.
  always_ff @(posedge clock) begin
    if (ctrl_reset) pend_q <= '0;
    else            pend_q <= pend_d;
  end

  assign pending_mask = pend_q;
`endif

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: lane-only vector table, directed multi-cycle
// sequences, then randomized traffic against a queue-based reference model.
// Define WB_PENDING_EN to also check pending_mask.
module tb_regfile_wb_sched;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic ctrl_reset;
  regfile_wb_sched_if wb ();
`ifdef WB_PENDING_EN
  logic [31:0] pending_mask;
`endif

  regfile_wb_sched #(.DEPTH(DEPTH)) dut (
    .clock(clock),
    .ctrl_reset(ctrl_reset),
    .wb(wb.slave)
`ifdef WB_PENDING_EN
    ,
    .pending_mask(pending_mask)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic        live;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;
  ent_t mq[$];

  logic        e_aen, e_ben;
  logic [4:0]  e_areg, e_breg;
  logic [31:0] e_adat, e_bdat, e_pend;

  // Consume the inputs present just before the coming edge; produce what the
  // ports must show after it.
  task automatic model_cycle();
    logic claim_a, claim_b, aw, bw, room, kill;
    ent_t n;
    e_aen = 0; e_areg = 0; e_adat = 0;
    e_ben = 0; e_breg = 0; e_bdat = 0;
    if (ctrl_reset) begin
      mq.delete();
      e_pend = 0;
      return;
    end
    claim_a = wb.lane_a_valid && wb.lane_a_rd != 0;
    claim_b = wb.lane_b_valid && wb.lane_b_rd != 0;
    aw = claim_a && !(claim_b && wb.lane_b_rd == wb.lane_a_rd);
    bw = claim_b;
    room = mq.size() < DEPTH;
    if (aw) begin e_aen = 1; e_areg = wb.lane_a_rd; e_adat = wb.lane_a_data; end
    if (bw) begin e_ben = 1; e_breg = wb.lane_b_rd; e_bdat = wb.lane_b_data; end
    foreach (mq[i])
      if ((claim_a && mq[i].rd == wb.lane_a_rd) || (claim_b && mq[i].rd == wb.lane_b_rd))
        mq[i].live = 0;
    if (mq.size() > 0) begin
      if (!mq[0].live) void'(mq.pop_front());
      else if (!aw) begin
        e_aen = 1; e_areg = mq[0].rd; e_adat = mq[0].data; void'(mq.pop_front());
      end else if (!bw) begin
        e_ben = 1; e_breg = mq[0].rd; e_bdat = mq[0].data; void'(mq.pop_front());
      end
    end
    if (wb.md_valid && room && wb.md_rd != 0) begin
      kill = (claim_a && wb.md_rd == wb.lane_a_rd) || (claim_b && wb.md_rd == wb.lane_b_rd);
      n.live = !kill; n.rd = wb.md_rd; n.data = wb.md_data;
      mq.push_back(n);
    end
    e_pend = 0;
    foreach (mq[i]) if (mq[i].live) e_pend[mq[i].rd] = 1;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    model_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    wb.lane_a_valid = 0; wb.lane_a_rd = 0; wb.lane_a_data = 0;
    wb.lane_b_valid = 0; wb.lane_b_rd = 0; wb.lane_b_data = 0;
    wb.md_valid = 0; wb.md_rd = 0; wb.md_data = 0;
  endtask

  task automatic set_lanes(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                           input logic bv, input logic [4:0] brd, input logic [31:0] bd);
    wb.lane_a_valid = av; wb.lane_a_rd = ard; wb.lane_a_data = ad;
    wb.lane_b_valid = bv; wb.lane_b_rd = brd; wb.lane_b_data = bd;
  endtask

  task automatic set_md(input logic v, input logic [4:0] rd, input logic [31:0] d);
    wb.md_valid = v; wb.md_rd = rd; wb.md_data = d;
  endtask

  task automatic expect_ports(input string tag,
                              input logic aen, input logic [4:0] areg, input logic [31:0] adat,
                              input logic ben, input logic [4:0] breg, input logic [31:0] bdat);
    chk({tag, ".A_en"},   32'(wb.A_ctrl_writeEnable), 32'(aen));
    chk({tag, ".A_reg"},  32'(wb.A_ctrl_writeReg),    32'(areg));
    chk({tag, ".A_data"}, wb.A_data_writeReg,         adat);
    chk({tag, ".B_en"},   32'(wb.B_ctrl_writeEnable), 32'(ben));
    chk({tag, ".B_reg"},  32'(wb.B_ctrl_writeReg),    32'(breg));
    chk({tag, ".B_data"}, wb.B_data_writeReg,         bdat);
    $display("%s: A(%0b r%0d 0x%0h) B(%0b r%0d 0x%0h) rdy=%0b", tag,
             wb.A_ctrl_writeEnable, wb.A_ctrl_writeReg, wb.A_data_writeReg,
             wb.B_ctrl_writeEnable, wb.B_ctrl_writeReg, wb.B_data_writeReg, wb.md_ready);
  endtask

  task automatic expect_pending(input string tag, input logic [31:0] exp);
`ifdef WB_PENDING_EN
    chk({tag, ".pending"}, pending_mask, exp);
`else
    if (exp === 32'hxxxx_xxxx) $display("%s: unused", tag);
`endif
  endtask

  // ---------------- lane-only vector table ----------------
  typedef struct {
    logic av; logic [4:0] ard; logic [31:0] ad;
    logic bv; logic [4:0] brd; logic [31:0] bd;
    logic xaen; logic [4:0] xareg; logic [31:0] xadat;
    logic xben; logic [4:0] xbreg; logic [31:0] xbdat;
  } vec_t;
  vec_t vt[6];

  initial begin
    vt[0] = '{1, 3, 32'h11, 1, 4, 32'h22,   1, 3, 32'h11, 1, 4, 32'h22};
    vt[1] = '{1, 5, 32'hAA, 1, 5, 32'hBB,   0, 0, 0,      1, 5, 32'hBB};
    vt[2] = '{1, 0, 32'h55, 0, 9, 32'h99,   0, 0, 0,      0, 0, 0};
    vt[3] = '{1, 6, 32'h66, 0, 0, 0,        1, 6, 32'h66, 0, 0, 0};
    vt[4] = '{0, 2, 32'h12, 1, 31, 32'hDEADBEEF, 0, 0, 0, 1, 31, 32'hDEADBEEF};
    vt[5] = '{1, 8, 32'h88, 1, 0, 32'h77,   1, 8, 32'h88, 0, 0, 0};

    idle_inputs();
    ctrl_reset = 1;
    cycle();
    cycle();
    ctrl_reset = 0;
    expect_ports("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.md_ready", 32'(wb.md_ready), 32'd1);
    expect_pending("reset", 32'd0);

    for (int i = 0; i < 6; i++) begin
      set_lanes(vt[i].av, vt[i].ard, vt[i].ad, vt[i].bv, vt[i].brd, vt[i].bd);
      cycle();
      expect_ports($sformatf("vec%0d", i), vt[i].xaen, vt[i].xareg, vt[i].xadat,
                   vt[i].xben, vt[i].xbreg, vt[i].xbdat);
    end
    idle_inputs();
    cycle();

    // MD result through idle port A.
    set_md(1, 7, 32'h77);
    cycle();
    expect_ports("md7.accept", 0, 0, 0, 0, 0, 0);
    expect_pending("md7.accept", 32'h80);
    set_md(0, 0, 0);
    cycle();
    expect_ports("md7.issue", 1, 7, 32'h77, 0, 0, 0);
    expect_pending("md7.issue", 32'd0);
    cycle();
    expect_ports("md7.empty", 0, 0, 0, 0, 0, 0);

    // Fill the queue while both lanes are busy, then drain via port B.
    set_lanes(1, 1, 32'h1, 1, 2, 32'h2);
    for (int k = 0; k < 4; k++) begin
      set_md(1, 5'(10 + k), 32'h100 + 32'(10 + k));
      cycle();
    end
    chk("fill.md_ready", 32'(wb.md_ready), 32'd0);
    expect_pending("fill", 32'h0000_3C00);
    set_md(0, 0, 0);
    set_lanes(1, 1, 32'h1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      expect_ports($sformatf("drain%0d", k), 1, 1, 32'h1, 1, 5'(10 + k), 32'h100 + 32'(10 + k));
      if (k == 0) chk("drain0.md_ready", 32'(wb.md_ready), 32'd1);
    end
    idle_inputs();
    cycle();
    expect_ports("drain.empty", 0, 0, 0, 0, 0, 0);

    // Younger lane write squashes a queued result to the same register.
    set_lanes(1, 1, 32'h1, 1, 2, 32'h2);
    set_md(1, 9, 32'h99);
    cycle();
    expect_pending("sq.queued", 32'h200);
    set_md(0, 0, 0);
    set_lanes(1, 9, 32'h01, 1, 2, 32'h2);
    cycle();
    expect_ports("sq.lane", 1, 9, 32'h01, 1, 2, 32'h2);
    expect_pending("sq.lane", 32'd0);
    idle_inputs();
    cycle();
    expect_ports("sq.after", 0, 0, 0, 0, 0, 0);

    // Reset discards queued entries.
    set_lanes(1, 1, 32'h1, 1, 2, 32'h2);
    for (int k = 0; k < 3; k++) begin
      set_md(1, 5'(20 + k), 32'h200 + 32'(k));
      cycle();
    end
    expect_pending("rst.queued", 32'h0070_0000);
    idle_inputs();
    ctrl_reset = 1;
    cycle();
    ctrl_reset = 0;
    expect_ports("rst.cycle", 0, 0, 0, 0, 0, 0);
    chk("rst.md_ready", 32'(wb.md_ready), 32'd1);
    expect_pending("rst.cycle", 32'd0);
    for (int k = 0; k < 2; k++) begin
      cycle();
      expect_ports($sformatf("rst.after%0d", k), 0, 0, 0, 0, 0, 0);
    end

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      ctrl_reset = ($urandom_range(0, 63) == 0);
      set_lanes($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      set_md($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom);
      cycle();
      chk("rnd.A_en",   32'(wb.A_ctrl_writeEnable), 32'(e_aen));
      chk("rnd.A_reg",  32'(wb.A_ctrl_writeReg),    32'(e_areg));
      chk("rnd.A_data", wb.A_data_writeReg,         e_adat);
      chk("rnd.B_en",   32'(wb.B_ctrl_writeEnable), 32'(e_ben));
      chk("rnd.B_reg",  32'(wb.B_ctrl_writeReg),    32'(e_breg));
      chk("rnd.B_data", wb.B_data_writeReg,         e_bdat);
      chk("rnd.md_ready", 32'(wb.md_ready), 32'(mq.size() < DEPTH));
      expect_pending("rnd", e_pend);
      $display("rnd%0d: A(%0b r%0d) B(%0b r%0d) q=%0d", c, wb.A_ctrl_writeEnable,
               wb.A_ctrl_writeReg, wb.B_ctrl_writeEnable, wb.B_ctrl_writeReg, mq.size());
    end
    ctrl_reset = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
